// File: rtl/emb_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the sequential embedding layer.
// The table functions stand in for the trained weight files named below.
package emb_pkg;

    localparam int DEF_N        = 10;
    localparam int DEF_CHAR_LEN = 8;
    localparam int DEF_EMB_DIM  = 24;
    localparam int DEF_N_LEN    = 16;
    localparam int DEF_VOCAB    = 200;

    localparam string EMB_ROM_FILE = "emb_weights.hex";
    localparam string POS_ROM_FILE = "pos_weights.hex";

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Trained embedding table, element j of the vector for code
    function automatic int emb_word(input int code, input int j);
        return code * 256 + j * 3 + 1;
    endfunction

    function automatic int pos_word(input int pos, input int j);
        return pos * 64 + j * 2 - 100;
    endfunction

    // Signed add clamped to the range of an n-bit two's-complement word
    function automatic int sat_add(input int a, input int b, input int n);
        int hi;
        int lo;
        int s;
        hi = (1 << (n - 1)) - 1;
        lo = -(1 << (n - 1));
        s  = a + b;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/emb_rom.sv
// Multi-port embedding ROM: LANES independent read ports, one registered read each.
// Codes outside the vocabulary read back as an all-zero vector.
module emb_rom
    import emb_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int CHAR_LEN = DEF_CHAR_LEN,
    parameter int EMB_DIM  = DEF_EMB_DIM,
    parameter int N_LEN    = DEF_N_LEN,
    parameter int VOCAB    = DEF_VOCAB
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [LANES*CHAR_LEN-1:0]        addr_i,
    output logic [LANES*EMB_DIM*N_LEN-1:0]   data_o
);

    logic [LANES*EMB_DIM*N_LEN-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                for (int j = 0; j < EMB_DIM; j++) begin
                    if (int'(addr_i[l*CHAR_LEN +: CHAR_LEN]) < VOCAB)
                        data_q[(l*EMB_DIM + j)*N_LEN +: N_LEN] <=
                            N_LEN'(emb_word(int'(addr_i[l*CHAR_LEN +: CHAR_LEN]), j));
                    else
                        data_q[(l*EMB_DIM + j)*N_LEN +: N_LEN] <= '0;
                end
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/emb_layer_seq.sv
// Time-multiplexed embedding layer: looks up N codes LANES at a time into an N x EMB_DIM matrix.
// Optional positional-embedding add (saturating) is enabled by defining EMB_POS_EMB_EN.
module emb_layer_seq
    import emb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CHAR_LEN = DEF_CHAR_LEN,
    parameter int EMB_DIM  = DEF_EMB_DIM,
    parameter int N_LEN    = DEF_N_LEN,
    parameter int VOCAB    = DEF_VOCAB,
    parameter int LANES    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic [N*CHAR_LEN-1:0]         d,
    output logic                          busy,
    output logic                          valid,
    output logic                          oob,
    output logic [N*EMB_DIM*N_LEN-1:0]    q
);

    localparam int GROUPS = N / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int GRP_W  = LANES * EMB_DIM * N_LEN;

    if (N % LANES != 0) begin : g_lane_chk
        $fatal(1, "emb_layer_seq: LANES must divide N");
    end

    state_t                      state_q;
    logic [GW-1:0]               grp_q;
    logic [GW-1:0]               wr_grp_q;
    logic                        wr_en_q;
    logic [LANES-1:0]            lane_oob_q;
    logic [LANES-1:0]            lane_oob_d;
    logic [N*CHAR_LEN-1:0]       d_q;
    logic [N*EMB_DIM*N_LEN-1:0]  q_q;
    logic                        busy_q;
    logic                        valid_q;
    logic                        oob_q;
    logic [LANES*CHAR_LEN-1:0]   rd_addr;
    logic [GRP_W-1:0]            rom_data;
    logic [GRP_W-1:0]            wb_data;

    always_comb begin
        rd_addr    = '0;
        lane_oob_d = '0;
        for (int l = 0; l < LANES; l++) begin
            rd_addr[l*CHAR_LEN +: CHAR_LEN] =
                d_q[(int'(grp_q)*LANES + l)*CHAR_LEN +: CHAR_LEN];
            lane_oob_d[l] =
                int'(d_q[(int'(grp_q)*LANES + l)*CHAR_LEN +: CHAR_LEN]) >= VOCAB;
        end
    end

    emb_rom #(
        .LANES    (LANES),
        .CHAR_LEN (CHAR_LEN),
        .EMB_DIM  (EMB_DIM),
        .N_LEN    (N_LEN),
        .VOCAB    (VOCAB)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_i (rd_addr),
        .data_o (rom_data)
    );

`ifdef EMB_POS_EMB_EN
    // Out-of-range lanes read zero from the ROM, so they end up with the pos vector alone
    always_comb begin
        wb_data = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < EMB_DIM; j++) begin
                wb_data[(l*EMB_DIM + j)*N_LEN +: N_LEN] = N_LEN'(sat_add(
                    int'($signed(rom_data[(l*EMB_DIM + j)*N_LEN +: N_LEN])),
                    pos_word(int'(wr_grp_q)*LANES + l, j),
                    N_LEN));
            end
        end
    end
`else
    assign wb_data = rom_data;
`endif

    // Writeback of group g-1 overlaps the address issue of group g
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grp_q      <= '0;
            wr_grp_q   <= '0;
            wr_en_q    <= 1'b0;
            lane_oob_q <= '0;
            d_q        <= '0;
            q_q        <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            wr_en_q    <= (state_q == S_FETCH);
            wr_grp_q   <= grp_q;
            lane_oob_q <= lane_oob_d;
            if (wr_en_q) begin
                q_q[int'(wr_grp_q)*GRP_W +: GRP_W] <= wb_data;
                if (|lane_oob_q) oob_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        d_q     <= d;
                        valid_q <= 1'b0;
                        oob_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        grp_q   <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (grp_q == GW'(GROUPS - 1)) state_q <= S_DRAIN;
                    else                          grp_q   <= grp_q + 1'b1;
                end
                S_DRAIN: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign oob   = oob_q;
    assign q     = q_q;

endmodule

// File: tb/tb_emb_layer_seq.sv
// Self-checking bench for emb_layer_seq: a LANES=2 and a LANES=N instance share one stimulus stream.
module tb_emb_layer_seq;

    localparam int N   = 10;
    localparam int CL  = 8;
    localparam int ED  = 24;
    localparam int NL  = 16;
    localparam int V   = 200;
    localparam int QW  = N * ED * NL;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          run   = 1'b0;
    logic [N*CL-1:0] d   = '0;
    logic          busy, valid, oob;
    logic          busy10, valid10, oob10;
    logic [QW-1:0] q, q10;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    emb_layer_seq #(.N(N), .CHAR_LEN(CL), .EMB_DIM(ED), .N_LEN(NL), .VOCAB(V), .LANES(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .d(d),
        .busy(busy), .valid(valid), .oob(oob), .q(q));

    emb_layer_seq #(.N(N), .CHAR_LEN(CL), .EMB_DIM(ED), .N_LEN(NL), .VOCAB(V), .LANES(N)) dut10 (
        .clk(clk), .rst_n(rst_n), .run(run), .d(d),
        .busy(busy10), .valid(valid10), .oob(oob10), .q(q10));

    typedef struct {
        logic [N*CL-1:0] d;
        int              exp_oob;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [N*CL-1:0] fill(input int base, input int step);
        logic [N*CL-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*CL +: CL] = CL'(base + i * step);
        return r;
    endfunction

    // Golden table: element j of code c is c*256 + 3j + 1, zero vector for c >= VOCAB
    function automatic logic [QW-1:0] golden(input logic [N*CL-1:0] dd);
        logic [QW-1:0] r;
        int c;
        r = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(dd[i*CL +: CL]);
            for (int j = 0; j < ED; j++)
                r[(i*ED + j)*NL +: NL] = (c < V) ? NL'(c * 256 + j * 3 + 1) : '0;
        end
        return r;
    endfunction

    function automatic int q_mism(input logic [QW-1:0] act, input logic [QW-1:0] exp);
        int m;
        m = 0;
        for (int e = 0; e < N * ED; e++)
            if (act[e*NL +: NL] !== exp[e*NL +: NL]) m++;
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [N*CL-1:0] dd);
        @(negedge clk);
        d   = dd;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt, output int lat10);
        int cyc;
        cyc      = 0;
        busy_cnt = busy ? 1 : 0;
        lat      = -1;
        lat10    = -1;
        while ((lat < 0 || lat10 < 0) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
            if (valid && lat < 0)     lat   = cyc;
            if (valid10 && lat10 < 0) lat10 = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, lat10;
        logic [N*CL-1:0] d7, d9;
        logic [QW-1:0]   held;
        logic [15:0]     s;

        vecs[0].d = fill(1, 1);                     vecs[0].exp_oob = 0;
        vecs[1].d = fill(5, 0);   vecs[1].d[3*CL +: CL] = 8'd250;
        vecs[1].exp_oob = 1;
        vecs[2].d = fill(199, 0); vecs[2].d[2*CL +: CL] = 8'd200;
        vecs[2].d[9*CL +: CL] = 8'd255; vecs[2].d[0 +: CL] = 8'd0;
        vecs[2].exp_oob = 1;
        vecs[3].d = fill(10, 10);                   vecs[3].exp_oob = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_q",     q_mism(q, '0), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_busy",  int'(busy), 0);
        check("reset_oob",   int'(oob), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            start(vecs[i].d);
            check($sformatf("v%0d_accept_valid", i), int'(valid), 0);
            check($sformatf("v%0d_accept_oob", i), int'(oob), 0);
            wait_done(lat, bcnt, lat10);
            check($sformatf("v%0d_latency", i), lat, 6);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 6);
            check($sformatf("v%0d_oob", i), int'(oob), vecs[i].exp_oob);
            check($sformatf("v%0d_q_mismatches", i), q_mism(q, golden(vecs[i].d)), 0);
            if (i == 0) begin
                check("v0_lanes10_latency", lat10, 2);
                check("v0_lanes10_q_mismatches", q_mism(q10, golden(vecs[0].d)), 0);
                held = q;
                repeat (3) @(posedge clk);
                #1;
                check("v0_valid_held", int'(valid), 1);
                check("v0_q_frozen", q_mism(q, held), 0);
            end
        end

        // Re-pulsed run during the sequence, including on the DRAIN edge, must be ignored
        d7 = fill(7, 0);
        d9 = fill(9, 0);
        start(d7);
        for (int k = 1; k <= 6; k++) begin
            if (k == 2 || k == 6) begin
                d   = d9;
                run = 1'b1;
            end
            @(posedge clk);
            #1;
            run = 1'b0;
        end
        check("repulse_valid", int'(valid), 1);
        check("repulse_busy", int'(busy), 0);
        check("repulse_q_mismatches", q_mism(q, golden(d7)), 0);
        d   = d9;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        check("rerun_valid_cleared", int'(valid), 0);
        check("rerun_busy", int'(busy), 1);
        wait_done(lat, bcnt, lat10);
        check("rerun_latency", lat, 6);
        check("rerun_q_mismatches", q_mism(q, golden(d9)), 0);

        // Asynchronous reset during the third FETCH cycle
        start(vecs[1].d);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_q",     q_mism(q, '0), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_busy",  int'(busy), 0);
        check("abort_oob",   int'(oob), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start(vecs[0].d);
        wait_done(lat, bcnt, lat10);
        check("post_abort_latency", lat, 6);
        check("post_abort_oob", int'(oob), 0);
        check("post_abort_q_mismatches", q_mism(q, golden(vecs[0].d)), 0);

        // Saturating add used by the positional-embedding path
        s = 16'(emb_pkg::sat_add(32'sh7FF0, 32'sh0020, 16));
        check("sat_high", int'(s), 32'h7FFF);
        s = 16'(emb_pkg::sat_add(-32752, -64, 16));
        check("sat_low", int'(s), 32'h8000);
        s = 16'(emb_pkg::sat_add(100, -30, 16));
        check("sat_none", int'(s), 70);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/emb_layer_seq.md
# emb_layer_seq

Time-multiplexed, parametrised successor to the fully parallel embedding layer. It latches `N` character codes and looks them up in a shared trained embedding ROM, `LANES` positions per cycle. It assembles the full `N×EMB_DIM` fixed-point matrix into an output register and optionally adds a positional embedding. It sits between the tokeniser/input buffer and the first dense layer, using the same `run`/`valid` handshake, and trades latency for `N/LANES`-fold fewer ROM read ports.

## Interface
Parameters:
- `N`, default 10: characters per sequence.
- `CHAR_LEN`, default 8: bits per character code.
- `EMB_DIM`, default 24: embedding vector length.
- `N_LEN`, default 16: bits per element, signed fixed-point.
- `VOCAB`, default 200: valid codes are 0..VOCAB-1.
- `LANES`, default 2: lookups per cycle. Must divide `N`; `GROUPS = N/LANES`.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset. Asynchronous and active-low.
- `run`, input, 1: start request, sampled on rising edge.
- `d`, input, `N*CHAR_LEN`: codes. Position i is `d[i*CHAR_LEN +: CHAR_LEN]`.
- `busy`, output, 1: a sequence is in flight.
- `valid`, output, 1: `q` holds a complete, stable result.
- `oob`, output, 1: at least one code in the current result was ≥ `VOCAB`.
- `q`, output, `N*EMB_DIM*N_LEN`: result. Position i is at `q[i*EMB_DIM*N_LEN +: EMB_DIM*N_LEN]`, and element j within it is at offset `j*N_LEN`.

## Operation
- FSM states:
  - IDLE → FETCH on an accepted run.
  - FETCH runs for `GROUPS` cycles, issuing group g addresses (positions g*LANES..g*LANES+LANES-1), then → DRAIN.
  - DRAIN lasts 1 cycle, writes the last group, then → IDLE.
- An accepted run is `run`=1 while in IDLE. On acceptance:
  - `d` is latched into an internal register.
  - `valid` and `oob` are cleared.
  - `busy` is set.
  - The group counter resets to 0.
- `run` while `busy`=1 is ignored. No queueing. The latched `d` is not affected.
- Changes on `d` after acceptance have no effect on the result.
- The ROM has 1-cycle registered read latency. Group g data is written into `q` one cycle after its address issue, overlapping the next issue.
- Any code ≥ `VOCAB`:
  - The lookup yields an all-zero vector for that position.
  - `oob` is set and stays sticky until the next accepted run.
- `q` positions not yet written in the current sequence keep their previous values. Only `valid`=1 guarantees consistency.
- `valid` is a level. It stays high from completion until the next accepted run or reset, and `q` is frozen during that time.
- When DRAIN → IDLE coincides with `run`=1, the run is not accepted (busy is still 1 that cycle). The requester must hold or re-assert `run`.

## Timing
- Reset values: `q`=0, `valid`=0, `busy`=0, `oob`=0, state IDLE, group counter 0.
- Reset asserted mid-sequence aborts immediately and asynchronously. No partial `valid`.
- Let edge E0 be the edge that accepts run:
  - `busy`=1 after E0.
  - Addresses are issued at edges E1..E_GROUPS.
  - `q` group writes occur at E2..E_(GROUPS+1).
  - `valid`=1 and `busy`=0 after E_(GROUPS+1).
- Latency run→valid is `GROUPS+1` cycles: 6 for the defaults, 2 for `LANES`=N.
- Throughput: one sequence per `GROUPS+2` cycles, since the next run is accepted only once back in IDLE.
- Arithmetic: the ROM word is taken as-is (N_LEN signed). No width growth except inside the optional add.

## Configuration
- `EMB_POS_EMB_EN` defined:
  - A second ROM of `N×EMB_DIM` signed N_LEN positional values is compiled in.
  - Each written element = sat(emb[code][j] + pos[i][j]), computed at the writeback edge. Latency is unchanged.
  - Saturation clamps to [-2^(N_LEN-1), 2^(N_LEN-1)-1].
  - OOB positions receive the pos vector alone.
- `EMB_POS_EMB_EN` undefined: no positional ROM or adders are compiled, and `q` is the raw lookup.

## Structure
- Shared package `emb_pkg` holds:
  - Default constants `N`, `CHAR_LEN`, `EMB_DIM`, `N_LEN`, `VOCAB`.
  - The FSM state enum (IDLE/FETCH/DRAIN).
  - The saturating signed add function.
  - The ROM init file names.
- Sub-module `emb_rom`: `LANES` independent read ports, one registered read each, contents loaded from the trained weight file.
- `LANES` divisibility is checked at elaboration; a violation is a fatal error.

## Test plan
- Defaults, reset released, `d`=codes 1..10, one-cycle run:
  - `busy` high for 6 cycles, `valid`=1 exactly 6 cycles after the run edge.
  - `q` equals the golden table rows 1..10, `oob`=0.
- `LANES`=N=10 build, same stimulus: `valid` after 2 cycles, with an identical `q`.
- Code 250 at position 3, others 5:
  - Position 3 vector is all zero, others are row 5.
  - `oob`=1, cleared on the next accepted run with in-range codes.
- `run` re-pulsed at cycles 2 and 6 after acceptance, with `d` changed:
  - Both pulses are ignored and the result reflects the original `d`.
  - A run one cycle after `valid` is accepted and clears `valid`.
- `rst_n` low at cycle 3 of FETCH:
  - All outputs are 0 asynchronously.
  - After release, a new run completes normally.
- `EMB_POS_EMB_EN` build, emb=0x7FF0 and pos=0x0020: element = 0x7FFF. With emb=0x8010 and pos=0xFFC0: element = 0x8000.
